// File: rtl/bcd_ms_timer.sv
// Reaction-timer scoring core: 1 kHz tick divider, saturating three-digit BCD
// millisecond counter and active-low seven-segment decoding of each digit.

module bcd_seg7 (
    input  logic [3:0] digit,
    output logic [1:7] seg
);

    // Bit [1] is segment a, bit [7] is segment g; a 0 lights the segment.
    always_comb begin
        seg = 7'b1111110;
        case (digit)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hF: seg = 7'b1111111;
            default: seg = 7'b1111110;
        endcase
    end

endmodule

module bcd_ms_timer #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned DIV_W = 16
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       en,
    output logic       tick,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic       sat,
    output logic [1:7] ss0,
    output logic [1:7] ss1,
    output logic [1:7] ss2
);

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;

    assign div_last = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge board_clk) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            tick    <= div_last;
        end
    end

    assign sat = (BCD2 == 4'd9) && (BCD1 == 4'd9) && (BCD0 == 4'd9);

    // Holding at 999 keeps the hundreds digit from ever carrying past 9.
    always_ff @(posedge board_clk) begin
        if (!reset) begin
            BCD0 <= '0;
            BCD1 <= '0;
            BCD2 <= '0;
        end else if (tick && en && !sat) begin
            if (BCD0 == 4'd9) begin
                BCD0 <= '0;
                if (BCD1 == 4'd9) begin
                    BCD1 <= '0;
                    BCD2 <= BCD2 + 4'd1;
                end else begin
                    BCD1 <= BCD1 + 4'd1;
                end
            end else begin
                BCD0 <= BCD0 + 4'd1;
            end
        end
    end

    bcd_seg7 u_seg0 (.digit(BCD0), .seg(ss0));
    bcd_seg7 u_seg1 (.digit(BCD1), .seg(ss1));
    bcd_seg7 u_seg2 (.digit(BCD2), .seg(ss2));

endmodule

// File: tb/tb_bcd_ms_timer.sv
// Directed self-checking bench for bcd_ms_timer with a 4-cycle tick divider,
// plus a standalone sweep of the seven-segment decoder.

module tb_bcd_ms_timer;

    logic       board_clk;
    logic       reset;
    logic       en;
    logic       tick;
    logic [3:0] BCD0, BCD1, BCD2;
    logic       sat;
    logic [1:7] ss0, ss1, ss2;

    logic [3:0] dec_digit;
    logic [1:7] dec_seg;

    int checks;
    int errors;

    bcd_ms_timer #(.DIV(4), .DIV_W(3)) dut (
        .board_clk(board_clk),
        .reset(reset),
        .en(en),
        .tick(tick),
        .BCD0(BCD0),
        .BCD1(BCD1),
        .BCD2(BCD2),
        .sat(sat),
        .ss0(ss0),
        .ss1(ss1),
        .ss2(ss2)
    );

    bcd_seg7 u_dec (.digit(dec_digit), .seg(dec_seg));

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic do_reset();
        @(negedge board_clk);
        reset = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge board_clk);
        reset = 1'b1;
    endtask

    // Waits for n tick pulses (sampled at negedge), lets the last one land, ends at a negedge.
    task automatic run_ticks(input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = n * 4 + 8;
        while (seen < n && budget > 0) begin
            @(negedge board_clk);
            if (tick === 1'b1) seen++;
            budget--;
        end
        if (seen < n) begin
            errors++;
            $display("FAIL run_ticks timeout: saw %0d ticks, required %0d", seen, n);
        end
        @(negedge board_clk);
    endtask

    task automatic check_count(input string name, input logic [3:0] e2, input logic [3:0] e1,
                               input logic [3:0] e0);
        checks++;
        if ({BCD2, BCD1, BCD0} !== {e2, e1, e0}) begin
            errors++;
            $display("FAIL %s count: got %h%h%h, required %h%h%h", name, BCD2, BCD1, BCD0, e2, e1, e0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({BCD2, BCD1, BCD0} !== 12'h000 || sat !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got bcd=%h%h%h sat=%b tick=%b, required 000 0 0",
                     BCD2, BCD1, BCD0, sat, tick);
        end
        checks++;
        if (ss0 !== 7'b0000001 || ss1 !== 7'b0000001 || ss2 !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_segs: got %b %b %b, required 0000001 x3", ss2, ss1, ss0);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge board_clk);
            checks++;
            if (tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL tick_period edge %0d: got %b, required %b", k, tick, (k % 4) == 0);
            end
        end
        check_count("idle_en0", 4'd0, 4'd0, 4'd0);
    endtask

    task automatic test_count_freeze();
        do_reset();
        en = 1'b1;
        run_ticks(12);
        check_count("count12", 4'd0, 4'd1, 4'd2);
        checks++;
        if (ss2 !== 7'b0000001 || ss1 !== 7'b1001111 || ss0 !== 7'b0010010) begin
            errors++;
            $display("FAIL segs012: got %b %b %b, required 0000001 1001111 0010010", ss2, ss1, ss0);
        end
        en = 1'b0;
        run_ticks(5);
        check_count("freeze", 4'd0, 4'd1, 4'd2);
        en = 1'b1;
        run_ticks(1);
        check_count("resume", 4'd0, 4'd1, 4'd3);
    endtask

    task automatic test_carry();
        do_reset();
        en = 1'b1;
        run_ticks(9);
        check_count("count009", 4'd0, 4'd0, 4'd9);
        run_ticks(1);
        check_count("carry010", 4'd0, 4'd1, 4'd0);
        run_ticks(89);
        check_count("count099", 4'd0, 4'd9, 4'd9);
        run_ticks(1);
        check_count("carry100", 4'd1, 4'd0, 4'd0);
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1'b1;
        run_ticks(998);
        check_count("count998", 4'd9, 4'd9, 4'd8);
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL sat998: got %b, required 0", sat);
        end
        run_ticks(1);
        check_count("count999", 4'd9, 4'd9, 4'd9);
        checks++;
        if (sat !== 1'b1) begin
            errors++;
            $display("FAIL sat999: got %b, required 1", sat);
        end
        run_ticks(6);
        check_count("hold999", 4'd9, 4'd9, 4'd9);
        checks++;
        if (sat !== 1'b1 || ss0 !== 7'b0000100 || ss1 !== 7'b0000100 || ss2 !== 7'b0000100) begin
            errors++;
            $display("FAIL hold_segs: got sat=%b %b %b %b, required 1 0000100 x3", sat, ss2, ss1, ss0);
        end
    endtask

    task automatic test_reset_priority();
        int budget;
        do_reset();
        en = 1'b1;
        run_ticks(3);
        check_count("pre_reset", 4'd0, 4'd0, 4'd3);
        budget = 8;
        do begin
            @(negedge board_clk);
            budget--;
        end while (tick !== 1'b1 && budget > 0);
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL find_tick: got %b, required 1", tick);
        end
        reset = 1'b0;
        @(negedge board_clk);
        check_count("reset_over_tick", 4'd0, 4'd0, 4'd0);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge board_clk);
            checks++;
            if (tick !== (k == 4) || {BCD2, BCD1, BCD0} !== 12'h000) begin
                errors++;
                $display("FAIL restart edge %0d: got tick=%b bcd=%h%h%h, required tick=%b bcd=000",
                         k, tick, BCD2, BCD1, BCD0, k == 4);
            end
        end
        @(negedge board_clk);
        check_count("first_after_reset", 4'd0, 4'd0, 4'd1);
    endtask

    task automatic test_decoder();
        logic [1:7] exp_tab [16];
        exp_tab[0]  = 7'b0000001;  exp_tab[1]  = 7'b1001111;
        exp_tab[2]  = 7'b0010010;  exp_tab[3]  = 7'b0000110;
        exp_tab[4]  = 7'b1001100;  exp_tab[5]  = 7'b0100100;
        exp_tab[6]  = 7'b0100000;  exp_tab[7]  = 7'b0001111;
        exp_tab[8]  = 7'b0000000;  exp_tab[9]  = 7'b0000100;
        exp_tab[10] = 7'b1111110;  exp_tab[11] = 7'b1111110;
        exp_tab[12] = 7'b1111110;  exp_tab[13] = 7'b1111110;
        exp_tab[14] = 7'b1111110;  exp_tab[15] = 7'b1111111;
        for (int d = 0; d < 16; d++) begin
            dec_digit = 4'(d);
            #1;
            checks++;
            if (dec_seg !== exp_tab[d]) begin
                errors++;
                $display("FAIL decode %h: got %b, required %b", d, dec_seg, exp_tab[d]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        en        = 1'b0;
        dec_digit = 4'h0;
        test_reset();
        test_count_freeze();
        test_carry();
        test_saturate();
        test_reset_priority();
        test_decoder();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
